// File: rtl/guarded_mode_fsm.sv
// Command-driven mode controller: IDLE/ARMED/RUN/DONE with fault accounting,
// a timed RUN phase and a permanent LOCKED state that only reset can leave.
module guarded_mode_fsm #(
    parameter int CMD_W    = 3,
    parameter int CNT_W    = 8,
    parameter int RUN_LEN  = 16,
    parameter int MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [CMD_W-1:0] cmd,
    output logic [2:0]       out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             locked,
    output logic [CNT_W-1:0] run_count
);

    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    localparam logic [CMD_W-1:0] CMD_NOP   = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_ARM   = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_START = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_ABORT = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_CLEAR = CMD_W'(4);

    localparam logic [CNT_W-1:0]  RUN_LAST = CNT_W'(RUN_LEN - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIM = FAIL_W'(MAX_FAIL);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        RUN    = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4,
        LOCKED = 3'd5
    } state_t;

    // Held as raw bits so codes 6 and 7 are representable and recover via default.
    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [FAIL_W-1:0] fail_cnt;
    logic [FAIL_W-1:0] fail_nxt;
    logic [CMD_W-1:0]  cmd_eff;
    logic              cmd_illegal;
    logic              fault;

    assign cmd_eff     = cmd_valid ? cmd : CMD_NOP;
    assign cmd_illegal = (cmd_eff > CMD_CLEAR);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = run_count;
        fail_nxt  = fail_cnt;
        fault     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_illegal || cmd_eff == CMD_START) begin
                    fault = 1'b1;
                end else if (cmd_eff == CMD_ARM) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (cmd_illegal) begin
                    fault = 1'b1;
                end else if (cmd_eff == CMD_START) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else if (cmd_eff == CMD_ABORT) begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (cmd_eff == CMD_ABORT) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cmd_illegal) begin
                    fault = 1'b1;
                end else if (run_count == RUN_LAST) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = run_count + 1'b1;
                end
            end
            DONE: begin
                if (cmd_eff == CMD_CLEAR) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    fail_nxt  = '0;
                end else if (cmd_illegal) begin
                    fault = 1'b1;
                end
            end
            ERROR: begin
                if (fail_cnt >= FAIL_LIM) begin
                    state_nxt = LOCKED;
                end else if (cmd_eff == CMD_CLEAR) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            LOCKED: begin
                state_nxt = LOCKED;
            end
            default: begin
                fault = 1'b1;
            end
        endcase

        // Every entry into ERROR is counted, saturating at the lockout threshold.
        if (fault) begin
            state_nxt = ERROR;
            if (fail_cnt < FAIL_LIM) begin
                fail_nxt = fail_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            run_count <= '0;
            fail_cnt  <= '0;
            out       <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_nxt;
            run_count <= cnt_nxt;
            fail_cnt  <= fail_nxt;
            out       <= state_nxt;
            busy      <= (state_nxt == RUN);
            done      <= (state_nxt == DONE);
            err       <= (state_nxt == ERROR) || (state_nxt == LOCKED);
            locked    <= (state_nxt == LOCKED);
        end
    end

endmodule
